// File: rtl/bus_pkg.sv
// Shared types for the bus fabric: FSM states, access modes, channel limits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_pkg;

  localparam int MAX_NDEV = 8;
  localparam int CH_W     = $clog2(MAX_NDEV);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mode_e;

endpackage

// File: rtl/bus_decode.sv
// Address window match with lowest-index priority; yields hit, channel and offset.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is valid whenever addr is valid.
module bus_decode
  import bus_pkg::*;
#(
  parameter int                 NDEV  = 4,
  parameter logic [NDEV*32-1:0] BASES = {NDEV{32'h0}},
  parameter logic [NDEV*8-1:0]  MASKS = {NDEV{8'd12}}
) (
  input  logic [31:0]     addr,
  output logic            hit,
  output logic [CH_W-1:0] idx,
  output logic [31:0]     offset
);

  logic [31:0] base;
  logic [31:0] win;

  // Scan from the top index down so the lowest matching window is written last and wins.
  always_comb begin
    hit    = 1'b0;
    idx    = '0;
    offset = '0;
    base   = '0;
    win    = '0;
    for (int i = NDEV - 1; i >= 0; i--) begin
      base = BASES[i*32 +: 32];
      win  = 32'hFFFF_FFFF << MASKS[i*8 +: 8];
      if ((addr & win) == (base & win)) begin
        hit    = 1'b1;
        idx    = CH_W'(i);
        offset = addr - base;
      end
    end
  end

endmodule

// File: rtl/bus_fabric.sv
// Single-master to NDEV-device bus bridge with window decode, ack timeout and error reporting.
// Latency: request in cycle N, device strobe in N+1, m_done no earlier than N+2.
// Backpressure: master holds its request until m_done; devices stall the access by withholding d_ack.
// Optional: define BUS_FABRIC_ERRLOG_EN to add err_addr / err_cnt error logging outputs.
module bus_fabric
  import bus_pkg::*;
#(
  parameter int                 NDEV    = 4,
  parameter int                 DW      = 32,
  parameter logic [NDEV*32-1:0] BASES   = {NDEV{32'h0}},
  parameter logic [NDEV*8-1:0]  MASKS   = {NDEV{8'd12}},
  parameter int                 TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_r_en,
  input  logic              m_w_en,
  input  logic [31:0]       m_addr,
  input  logic [1:0]        m_mode,
  input  logic [DW-1:0]     m_w_data,
  output logic [DW-1:0]     m_r_data,
  output logic              m_done,
  output logic              m_busy,
  output logic [NDEV-1:0]   d_r_en,
  output logic [NDEV-1:0]   d_w_en,
  output logic [31:0]       d_addr,
  output logic [DW-1:0]     d_w_data,
  output logic [1:0]        d_mode,
  input  logic [NDEV*DW-1:0] d_r_data,
  input  logic [NDEV-1:0]   d_ack,
  output logic              m_err
`ifdef BUS_FABRIC_ERRLOG_EN
  ,
  output logic [31:0]       err_addr,
  output logic [7:0]        err_cnt
`endif
);

  state_e          state;
  state_e          state_nx;
  logic [NDEV-1:0] sel_oh;     // one-hot selected channel, all-zero when unmapped
  logic [NDEV-1:0] sel_nx;
  logic            is_wr;
  logic            pend_rd;    // read half of a simultaneous read+write, served after the write
  logic [7:0]      cnt;
  logic            req;
  logic            mapped;
  logic            ack_hit;
  logic [DW-1:0]   rd_sel;
  logic            dec_hit;
  logic [CH_W-1:0] dec_idx;
  logic [31:0]     dec_off;

  bus_decode #(
    .NDEV  (NDEV),
    .BASES (BASES),
    .MASKS (MASKS)
  ) u_decode (
    .addr   (m_addr),
    .hit    (dec_hit),
    .idx    (dec_idx),
    .offset (dec_off)
  );

  assign req     = m_r_en | m_w_en;
  assign mapped  = |sel_oh;
  assign ack_hit = |(d_ack & sel_oh);
  assign m_busy  = (state != IDLE);
  assign m_done  = (state == RESP) || (state == ERR);
  assign d_r_en  = (state == ACCESS && !is_wr) ? sel_oh : '0;
  assign d_w_en  = (state == ACCESS &&  is_wr) ? sel_oh : '0;

  // Turn the decoder index into a one-hot select and pick the selected channel's read data.
  always_comb begin
    sel_nx = '0;
    rd_sel = '0;
    for (int i = 0; i < NDEV; i++) begin
      sel_nx[i] = dec_hit && (dec_idx == CH_W'(i));
      if (sel_oh[i]) rd_sel = d_r_data[i*DW +: DW];
    end
  end

  // Next-state logic. An unmapped request spends one strobe-less ACCESS cycle before ERR,
  // so error completions keep the same two-cycle minimum latency as good ones.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = ACCESS;
      ACCESS: begin
        if (!mapped)                        state_nx = ERR;
        else if (ack_hit)                   state_nx = RESP;
        else if (cnt == 8'(TIMEOUT - 1))    state_nx = ERR;
      end
      RESP:    state_nx = pend_rd ? ACCESS : IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register plus the request/response datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel_oh   <= '0;
      is_wr    <= 1'b0;
      pend_rd  <= 1'b0;
      cnt      <= '0;
      d_addr   <= '0;
      d_w_data <= '0;
      d_mode   <= '0;
      m_r_data <= '0;
      m_err    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (req) begin
            sel_oh   <= sel_nx;
            d_addr   <= dec_off;
            d_w_data <= m_w_data;
            d_mode   <= m_mode;
            is_wr    <= m_w_en;
            pend_rd  <= m_w_en & m_r_en;
            cnt      <= '0;
          end
        end
        ACCESS: begin
          if (state_nx == RESP) begin
            if (!is_wr) m_r_data <= rd_sel;
            m_err <= 1'b0;
          end else if (state_nx == ERR) begin
            m_r_data <= '0;
            m_err    <= 1'b1;
            pend_rd  <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          if (pend_rd) begin
            is_wr   <= 1'b0;
            pend_rd <= 1'b0;
            cnt     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BUS_FABRIC_ERRLOG_EN
  logic [31:0] req_addr;

  // Remember the faulting master address and count errors, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr <= '0;
      err_addr <= '0;
      err_cnt  <= '0;
    end else begin
      if (state == IDLE && req) req_addr <= m_addr;
      if (state == ACCESS && state_nx == ERR) begin
        err_addr <= req_addr;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bus_fabric.sv
// Directed bench for bus_fabric: two channels (0x50/16B, 0x1000/4KB), TIMEOUT=4.
// Latency: inputs driven 2 time units after each rising edge, outputs checked right after.
// Backpressure: device acks are scripted per cycle, including a withheld ack and a stray ack.
module tb_bus_fabric;
  import bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_r_en, m_w_en;
  logic [31:0] m_addr;
  logic [1:0]  m_mode;
  logic [31:0] m_w_data, m_r_data;
  logic        m_done, m_busy, m_err;
  logic [1:0]  d_r_en, d_w_en, d_ack;
  logic [31:0] d_addr, d_w_data;
  logic [1:0]  d_mode;
  logic [63:0] d_r_data;
`ifdef BUS_FABRIC_ERRLOG_EN
  logic [31:0] err_addr;
  logic [7:0]  err_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  bus_fabric #(
    .NDEV    (2),
    .DW      (32),
    .BASES   ({32'h0000_1000, 32'h0000_0050}),
    .MASKS   ({8'd12, 8'd4}),
    .TIMEOUT (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m_r_en   (m_r_en),
    .m_w_en   (m_w_en),
    .m_addr   (m_addr),
    .m_mode   (m_mode),
    .m_w_data (m_w_data),
    .m_r_data (m_r_data),
    .m_done   (m_done),
    .m_busy   (m_busy),
    .d_r_en   (d_r_en),
    .d_w_en   (d_w_en),
    .d_addr   (d_addr),
    .d_w_data (d_w_data),
    .d_mode   (d_mode),
    .d_r_data (d_r_data),
    .d_ack    (d_ack),
    .m_err    (m_err)
`ifdef BUS_FABRIC_ERRLOG_EN
    ,
    .err_addr (err_addr),
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; m_r_en = 1'b0; m_w_en = 1'b0; m_addr = '0; m_mode = '0;
    m_w_data = '0; d_r_data = '0; d_ack = '0;
    tick(); tick();
    // Reset values.
    chk("rst_done", 32'(m_done), 0);
    chk("rst_busy", 32'(m_busy), 0);
    chk("rst_err",  32'(m_err), 0);
    chk("rst_rdata", m_r_data, 0);
    chk("rst_ren", 32'(d_r_en), 0);
    chk("rst_wen", 32'(d_w_en), 0);
    chk("rst_daddr", d_addr, 0);
    chk("rst_wdata", d_w_data, 0);
    chk("rst_mode", 32'(d_mode), 0);
`ifdef BUS_FABRIC_ERRLOG_EN
    chk("rst_erraddr", err_addr, 0);
    chk("rst_errcnt", 32'(err_cnt), 0);
`endif
    rst = 1'b0;
    tick();

    // Read 0x1004 on ch1, ack in first ACCESS cycle.
    m_r_en = 1'b1; m_addr = 32'h1004; m_mode = WORD;          // cycle N
    tick();                                                    // N+1
    chk("rd_ren", 32'(d_r_en), 2);
    chk("rd_wen", 32'(d_w_en), 0);
    chk("rd_daddr", d_addr, 32'h4);
    chk("rd_mode", 32'(d_mode), 2);
    chk("rd_busy", 32'(m_busy), 1);
    chk("rd_done_n1", 32'(m_done), 0);
    d_ack = 2'b10; d_r_data = {32'hDEAD_BEEF, 32'h0};
    tick();                                                    // N+2
    chk("rd_done_n2", 32'(m_done), 1);
    chk("rd_rdata", m_r_data, 32'hDEAD_BEEF);
    chk("rd_err", 32'(m_err), 0);
    m_r_en = 1'b0; d_ack = '0; d_r_data = '0;
    tick();
    chk("rd_idle_done", 32'(m_done), 0);
    chk("rd_idle_busy", 32'(m_busy), 0);

    // Write 0x54 on ch0, stray ack from ch1, ch0 acks in third ACCESS cycle.
    m_w_en = 1'b1; m_addr = 32'h54; m_w_data = 32'h41; m_mode = BYTE;
    tick();                                                    // N+1
    chk("wr_wen1", 32'(d_w_en), 1);
    chk("wr_ren1", 32'(d_r_en), 0);
    chk("wr_wdata", d_w_data, 32'h41);
    chk("wr_daddr", d_addr, 32'h4);
    d_ack = 2'b10;
    tick();                                                    // N+2
    chk("wr_stray_done", 32'(m_done), 0);
    chk("wr_wen2", 32'(d_w_en), 1);
    d_ack = 2'b00;
    tick();                                                    // N+3
    chk("wr_wen3", 32'(d_w_en), 1);
    chk("wr_done_n3", 32'(m_done), 0);
    d_ack = 2'b01;
    tick();                                                    // N+4
    chk("wr_done_n4", 32'(m_done), 1);
    chk("wr_err", 32'(m_err), 0);
    chk("wr_wen4", 32'(d_w_en), 0);
    chk("wr_rdata_hold", m_r_data, 32'hDEAD_BEEF);
    m_w_en = 1'b0; d_ack = '0;
    tick();

    // Unmapped read 0x8000.
    m_r_en = 1'b1; m_addr = 32'h8000; m_mode = WORD;
    tick();                                                    // N+1
    chk("um_ren", 32'(d_r_en), 0);
    chk("um_wen", 32'(d_w_en), 0);
    chk("um_done_n1", 32'(m_done), 0);
    tick();                                                    // N+2
    chk("um_done_n2", 32'(m_done), 1);
    chk("um_err", 32'(m_err), 1);
    chk("um_rdata", m_r_data, 0);
`ifdef BUS_FABRIC_ERRLOG_EN
    chk("um_erraddr", err_addr, 32'h8000);
    chk("um_errcnt", 32'(err_cnt), 1);
`endif
    m_r_en = 1'b0;
    tick();
    chk("um_err_hold", 32'(m_err), 1);

    // Timeout: read 0x1008, ch1 never acks.
    m_r_en = 1'b1; m_addr = 32'h1008;
    for (int c = 1; c <= 4; c++) begin
      tick();                                                  // N+1..N+4
      chk($sformatf("to_ren_%0d", c), 32'(d_r_en), 2);
      chk($sformatf("to_done_%0d", c), 32'(m_done), 0);
    end
    tick();                                                    // N+5
    chk("to_ren_5", 32'(d_r_en), 0);
    chk("to_done", 32'(m_done), 1);
    chk("to_err", 32'(m_err), 1);
    chk("to_rdata", m_r_data, 0);
`ifdef BUS_FABRIC_ERRLOG_EN
    chk("to_erraddr", err_addr, 32'h1008);
    chk("to_errcnt", 32'(err_cnt), 2);
`endif
    m_r_en = 1'b0;
    tick();

    // Simultaneous read and write to 0x1010: write first, read strobe right after m_done.
    m_r_en = 1'b1; m_w_en = 1'b1; m_addr = 32'h1010; m_w_data = 32'h1234;
    tick();                                                    // N+1
    chk("rw_wen", 32'(d_w_en), 2);
    chk("rw_ren", 32'(d_r_en), 0);
    chk("rw_wdata", d_w_data, 32'h1234);
    d_ack = 2'b10;
    tick();                                                    // N+2
    chk("rw_wdone", 32'(m_done), 1);
    chk("rw_werr", 32'(m_err), 0);
    chk("rw_wen_off", 32'(d_w_en), 0);
    m_w_en = 1'b0; d_ack = '0;
    tick();                                                    // N+3
    chk("rw_rd_ren", 32'(d_r_en), 2);
    chk("rw_rd_wen", 32'(d_w_en), 0);
    chk("rw_rd_daddr", d_addr, 32'h10);
    chk("rw_rd_done0", 32'(m_done), 0);
    d_ack = 2'b10; d_r_data = {32'hCAFE_F00D, 32'h0};
    tick();                                                    // N+4
    chk("rw_rdone", 32'(m_done), 1);
    chk("rw_rdata", m_r_data, 32'hCAFE_F00D);
    m_r_en = 1'b0; d_ack = '0;
    tick();
    chk("rw_idle", 32'(m_busy), 0);

    // Reset in the middle of an access, then a late ack from ch1.
    m_r_en = 1'b1; m_addr = 32'h1000;
    tick();                                                    // N+1
    chk("ra_ren", 32'(d_r_en), 2);
    rst = 1'b1;
    tick();                                                    // N+2
    rst = 1'b0; m_r_en = 1'b0; d_ack = 2'b10;
    chk("ra_done", 32'(m_done), 0);
    chk("ra_busy", 32'(m_busy), 0);
    chk("ra_ren2", 32'(d_r_en), 0);
    chk("ra_daddr", d_addr, 0);
    chk("ra_rdata", m_r_data, 0);
    chk("ra_wdata", d_w_data, 0);
    tick();
    chk("ra_late_done", 32'(m_done), 0);
    chk("ra_late_busy", 32'(m_busy), 0);
    chk("ra_late_err", 32'(m_err), 0);
    d_ack = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_fabric.md
BUS_FABRIC -- requirements
Module: bus_fabric

Interface
REQ-001 SHALL have parameter NDEV, default 4: number of device channels, 1..8.
REQ-002 SHALL have parameter DW, default 32: data width, 32 only.
REQ-003 SHALL have parameter BASES, default {NDEV{32'h0}}: packed per-channel base address, NDEV*32 bits.
REQ-004 SHALL have parameter MASKS, default {NDEV{8'd12}}: packed per-channel window size as log2 bytes, NDEV*8 bits.
REQ-005 SHALL have parameter TIMEOUT, default 16: cycles to wait for a device ack, 2..255.
REQ-006 SHALL have port clk, input, 1 bit: single clock.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have ports m_r_en, m_w_en, input, 1 bit each: master read/write request, held until m_done.
REQ-009 SHALL have ports m_addr, input, 32 bits, and m_mode, input, 2 bits: address and byte/half/word mode.
REQ-010 SHALL have ports m_w_data, input, DW bits, and m_r_data, output, DW bits.
REQ-011 SHALL have ports m_done, output, 1 bit (one-cycle completion pulse), and m_busy, output, 1 bit.
REQ-012 SHALL have ports d_r_en, d_w_en, output, NDEV bits each: per-channel strobes.
REQ-013 SHALL have ports d_addr, output, 32 bits: offset address (m_addr minus BASES[i]).
REQ-014 SHALL have ports d_w_data, output, DW bits, and d_mode, output, 2 bits.
REQ-015 SHALL have ports d_r_data, input, NDEV*DW bits, and d_ack, input, NDEV bits.
REQ-016 SHALL have port m_err, output, 1 bit: last transaction unmapped or timed out.

Function
REQ-017 SHALL use FSM states IDLE, ACCESS, RESP, ERR.
REQ-018 IDLE: on m_r_en|m_w_en, decode and register the channel, offset address, mode, write data and direction, then go to ACCESS.
REQ-019 Decode: a channel hits when m_addr[31:MASKS[i]] == BASES[i][31:MASKS[i]]; if several windows overlap, the lowest index SHALL win.
REQ-020 No hit: go to ERR directly, with no device strobe.
REQ-021 ACCESS: assert exactly one d_r_en/d_w_en bit; wait for that channel's d_ack, which may arrive in the first ACCESS cycle.
REQ-022 On ack: capture d_r_data of the selected channel into m_r_data (reads only), then go to RESP.
REQ-023 RESP: pulse m_done for one cycle, clear m_err, return to IDLE.
REQ-024 Minimum latency: request seen in cycle N, strobe in N+1, m_done in N+2.
REQ-025 Timeout: an 8-bit counter SHALL clear on ACCESS entry; reaching TIMEOUT without ack goes to ERR.
REQ-026 ERR: pulse m_done, set m_err, drive m_r_data=0, return to IDLE.
REQ-027 Acks on non-selected channels SHALL be ignored.
REQ-028 m_r_data SHALL hold its value until the next read completes.
REQ-029 Simultaneous m_r_en and m_w_en: the write is served first; the read stays requested and starts in the cycle after m_done.
REQ-030 m_busy SHALL be high in every state except IDLE.
REQ-031 Master inputs changing outside IDLE SHALL be ignored.

Reset
REQ-032 rst SHALL force IDLE with m_done=0, m_busy=0, m_err=0, m_r_data=0, d_r_en=0, d_w_en=0, d_addr=0, d_w_data=0, d_mode=0, and counter=0.
REQ-033 rst in ACCESS SHALL abort the access; no m_done is issued, and a late d_ack after reset is ignored.

Configuration
REQ-034 Macro BUS_FABRIC_ERRLOG_EN, when defined, SHALL add an output err_addr, 32 bits, that latches m_addr on ERR entry (reset 0), plus an output err_cnt, 8 bits, saturating count of errors.
REQ-035 Without BUS_FABRIC_ERRLOG_EN these ports and registers SHALL be absent; m_err behaviour is unchanged.

Structure
REQ-036 Package bus_pkg SHALL hold the FSM state enum, the mode encoding (BYTE=0, HALF=1, WORD=2) and a MAX_NDEV=8 constant.
REQ-037 Sub-module bus_decode SHALL contain the combinational window match and priority encoder; it outputs a hit flag, channel index and offset address.

Verification
REQ-038 NDEV=2, BASES={0x50,0x1000}, MASKS={4,12}: read 0x1004, ch1 acks on first ACCESS cycle with 0xDEADBEEF -> d_addr=0x4, m_done at N+2, m_r_data=0xDEADBEEF.
REQ-039 Write 0x54 data 0x41, ch0 acks after 3 cycles -> d_w_en[0] held 3 cycles, d_w_data=0x41, m_done at N+4, m_err=0.
REQ-040 Read 0x8000 (unmapped) -> no strobe, m_done at N+2, m_err=1, m_r_data=0; with the macro defined, err_addr=0x8000.
REQ-041 TIMEOUT=4, ch1 never acks -> strobe for 4 cycles, then an ERR m_done with m_err=1.
REQ-042 r_en and w_en asserted together on ch1 -> write strobe completes first, then the read strobe begins the cycle after m_done.
REQ-043 rst pulsed mid-ACCESS, then ch1 acks -> all outputs zero, no m_done, FSM in IDLE.
